jtag_tap_slave: RTL and testbench

- JTAG target-side TAP: the responder to the `jtag` master, which drives TCK/TMS/TDI and samples TDO.
- Oversamples the JTAG pins in the system clock domain and runs the IEEE 1149.1 16-state TAP FSM.
- Holds a 10-bit IR plus three data registers: DATA (8-bit, user-visible), IDCODE (32-bit) and BYPASS (1-bit).
- Used as the loopback target for master bring-up and as a debug port into user logic.

---
 rtl/jtag_pkg.sv | 32 +++
 rtl/jtag_tap_slave_if.sv | 10 +
 rtl/jtag_pin_sync.sv | 38 +++
 rtl/jtag_tap_slave.sv | 105 ++++++++++
 tb/tb_jtag_tap_slave.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, default instruction codes and widths, IEEE 1149.1 next-state function
package jtag_pkg;
  localparam int IR_LEN_DEF = 10;
  localparam int DR_LEN_DEF = 8;
  localparam logic [9:0] INSTR_DATA_DEF = 10'b0110011100;
  localparam logic [9:0] INSTR_IDCODE_DEF = 10'b0000000001;
  localparam logic [31:0] IDCODE_DEF = 32'h1234_5A5B;
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
    UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;
  function automatic tap_state_t tap_next(tap_state_t s, logic tms);
    case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PAU_DR;
      PAU_DR:  return tms ? EX2_DR : PAU_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PAU_IR;
      PAU_IR:  return tms ? EX2_IR : PAU_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      default: return tms ? SEL_DR : RTI;
    endcase
  endfunction
endpackage

// File: rtl/jtag_tap_slave_if.sv
// jtag_tap_slave_if: JTAG pin bundle (tck/tms/tdi from master, tdo/tdo_en from target) with master/slave modports
interface jtag_tap_slave_if;
  logic tck;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_en;
  modport master (output tck, tms, tdi, input tdo, tdo_en);
  modport slave (input tck, tms, tdi, output tdo, tdo_en);
endinterface

// File: rtl/jtag_pin_sync.sv
// jtag_pin_sync: 2-flop synchronizers for tck/tms/tdi with tck rise/fall detect; ports clk, rst, tck, tms, tdi -> tck_rise, tck_fall, tms_s, tdi_s
module jtag_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);
  logic [1:0] tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic prev_q, prev_d;
  always_comb begin
    tck_d = {tck_q[0], tck};
    tms_d = {tms_q[0], tms};
    tdi_d = {tdi_q[0], tdi};
    prev_d = tck_q[1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_q <= '0;
      tms_q <= '0;
      tdi_q <= '0;
      prev_q <= 1'b0;
    end else begin
      tck_q <= tck_d;
      tms_q <= tms_d;
      tdi_q <= tdi_d;
      prev_q <= prev_d;
    end
  end
  assign tck_rise = tck_q[1] & ~prev_q;
  assign tck_fall = ~tck_q[1] & prev_q;
  assign tms_s = tms_q[1];
  assign tdi_s = tdi_q[1];
endmodule

// File: rtl/jtag_tap_slave.sv
// jtag_tap_slave: oversampled IEEE 1149.1 TAP target with IR, DATA, IDCODE, BYPASS; ports clk, rst, jtag (slave pins), cap_data, dr_data, dr_valid, ir_value, tap_state
module jtag_tap_slave
  import jtag_pkg::*;
#(
  parameter int IR_LEN = IR_LEN_DEF,
  parameter int DR_LEN = DR_LEN_DEF,
  parameter logic [31:0] IDCODE_VAL = IDCODE_DEF,
  parameter logic [IR_LEN-1:0] INSTR_DATA = IR_LEN'(INSTR_DATA_DEF),
  parameter logic [IR_LEN-1:0] INSTR_IDCODE = IR_LEN'(INSTR_IDCODE_DEF)
) (
  input  logic clk,
  input  logic rst,
  jtag_tap_slave_if.slave jtag,
  input  logic [DR_LEN-1:0] cap_data,
  output logic [DR_LEN-1:0] dr_data,
  output logic dr_valid,
  output logic [IR_LEN-1:0] ir_value,
  output logic [3:0] tap_state
);
  logic tck_rise, tck_fall, tms_s, tdi_s;
  tap_state_t state_q, state_d;
  logic [IR_LEN-1:0] ir_q, ir_d, ir_sh_q, ir_sh_d;
  logic [DR_LEN-1:0] dr_sh_q, dr_sh_d, dr_q, dr_d;
  logic [31:0] id_sh_q, id_sh_d;
  logic byp_q, byp_d, tdo_q, tdo_d, tdo_en_q, tdo_en_d, valid_q, valid_d;
  logic sel_data, sel_id, dr_lsb;
  jtag_pin_sync u_sync (
    .clk(clk),
    .rst(rst),
    .tck(jtag.tck),
    .tms(jtag.tms),
    .tdi(jtag.tdi),
    .tck_rise(tck_rise),
    .tck_fall(tck_fall),
    .tms_s(tms_s),
    .tdi_s(tdi_s)
  );
  always_comb begin
    sel_data = ir_q == INSTR_DATA;
    sel_id = ir_q == INSTR_IDCODE;
    dr_lsb = sel_data ? dr_sh_q[0] : sel_id ? id_sh_q[0] : byp_q;
    state_d = state_q;
    ir_d = ir_q;
    ir_sh_d = ir_sh_q;
    dr_sh_d = dr_sh_q;
    dr_d = dr_q;
    id_sh_d = id_sh_q;
    byp_d = byp_q;
    tdo_d = tdo_q;
    tdo_en_d = tdo_en_q;
    valid_d = 1'b0;
    if (tck_rise) begin
      state_d = tap_next(state_q, tms_s);
      tdo_en_d = state_d == SH_DR || state_d == SH_IR;
      if (state_q == TLR) ir_d = INSTR_IDCODE;
      if (state_q == CAP_IR) ir_sh_d = IR_LEN'(1);
      if (state_q == SH_IR) ir_sh_d = {tdi_s, ir_sh_q[IR_LEN-1:1]};
      if (state_q == CAP_DR || state_q == SH_DR) begin
        if (sel_data) dr_sh_d = state_q == CAP_DR ? cap_data : {tdi_s, dr_sh_q[DR_LEN-1:1]};
        else if (sel_id) id_sh_d = state_q == CAP_DR ? IDCODE_VAL : {tdi_s, id_sh_q[31:1]};
        else byp_d = state_q == CAP_DR ? 1'b0 : tdi_s;
      end
    end
    if (tck_fall) begin
      if (state_q == SH_IR) tdo_d = ir_sh_q[0];
      if (state_q == SH_DR) tdo_d = dr_lsb;
      if (state_q == UPD_IR) ir_d = ir_sh_q;
      if (state_q == UPD_DR && sel_data) begin
        dr_d = dr_sh_q;
        valid_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TLR;
      ir_q <= INSTR_IDCODE;
      ir_sh_q <= '0;
      dr_sh_q <= '0;
      dr_q <= '0;
      id_sh_q <= '0;
      byp_q <= 1'b0;
      tdo_q <= 1'b0;
      tdo_en_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      ir_sh_q <= ir_sh_d;
      dr_sh_q <= dr_sh_d;
      dr_q <= dr_d;
      id_sh_q <= id_sh_d;
      byp_q <= byp_d;
      tdo_q <= tdo_d;
      tdo_en_q <= tdo_en_d;
      valid_q <= valid_d;
    end
  end
  assign jtag.tdo = tdo_q;
  assign jtag.tdo_en = tdo_en_q;
  assign dr_data = dr_q;
  assign dr_valid = valid_q;
  assign ir_value = ir_q;
  assign tap_state = state_q;
endmodule

// File: tb/tb_jtag_tap_slave.sv
// tb_jtag_tap_slave: randomized scoreboard bench driving JTAG pins and checking tdo stream, DR updates, IR and reset behaviour
module tb_jtag_tap_slave;
  import jtag_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] cap_data, dr_data;
  logic dr_valid;
  logic [9:0] ir_value;
  logic [3:0] tap_state;
  int checks = 0;
  int errors = 0;
  logic mon_on = 1'b0;
  logic prev_valid = 1'b0;
  logic [9:0] model_ir;
  logic exp_tdo_q[$];
  logic [7:0] exp_dr_q[$];
  always #5 clk = ~clk;
  jtag_tap_slave_if jif();
  jtag_tap_slave dut (
    .clk(clk),
    .rst(rst),
    .jtag(jif.slave),
    .cap_data(cap_data),
    .dr_data(dr_data),
    .dr_valid(dr_valid),
    .ir_value(ir_value),
    .tap_state(tap_state)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(posedge jif.tck) begin
    if (mon_on && jif.tdo_en === 1'b1) begin
      if (exp_tdo_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tdo_extra: got unexpected shift bit %0b expected none", jif.tdo);
      end else chk("tdo", 32'(jif.tdo), 32'(exp_tdo_q.pop_front()));
    end
  end
  always @(negedge clk) begin
    if (mon_on && prev_valid) chk("dr_valid_width", 32'(dr_valid), 32'd0);
    if (mon_on && dr_valid) begin
      if (exp_dr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dr_extra: got dr_valid with dr_data %0h expected no update", dr_data);
      end else chk("dr_data", 32'(dr_data), 32'(exp_dr_q.pop_front()));
    end
    prev_valid <= dr_valid;
  end
  task automatic tick(input logic m, input logic d);
    jif.tms = m;
    jif.tdi = d;
    repeat (4) @(negedge clk);
    jif.tck = 1'b1;
    repeat (4) @(negedge clk);
    jif.tck = 1'b0;
  endtask
  function automatic logic model_tdo(input int i, input logic [63:0] din, input logic [7:0] cap);
    logic [31:0] id;
    id = IDCODE_DEF;
    if (model_ir == INSTR_DATA_DEF) return cap[i];
    if (model_ir == INSTR_IDCODE_DEF) return id[i];
    return i == 0 ? 1'b0 : din[i-1];
  endfunction
  task automatic goto_tlr();
    repeat (5) tick(1'b1, 1'($urandom));
    chk("tlr_state", 32'(tap_state), 32'(TLR));
    tick(1'b1, 1'b0);
    chk("tlr_ir", 32'(ir_value), 32'(INSTR_IDCODE_DEF));
    model_ir = INSTR_IDCODE_DEF;
    tick(1'b0, 1'b0);
  endtask
  task automatic shift_ir(input logic [9:0] code);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      exp_tdo_q.push_back(i == 0);
      tick(i == 9, code[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    model_ir = code;
    chk("ir_value", 32'(ir_value), 32'(code));
    chk("ir_rti", 32'(tap_state), 32'(RTI));
  endtask
  task automatic shift_dr(input int n, input logic [63:0] din, input logic [7:0] cap, input int pause_at);
    cap_data = cap;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      exp_tdo_q.push_back(model_tdo(i, din, cap));
      if (i == pause_at && i != n - 1) begin
        tick(1'b1, din[i]);
        tick(1'b0, 1'b0);
        repeat ($urandom_range(0, 3)) tick(1'b0, 1'($urandom));
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
      end else tick(i == n - 1, din[i]);
    end
    if (model_ir == INSTR_DATA_DEF && n == 8) exp_dr_q.push_back(din[7:0]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
  initial begin
    logic [9:0] code;
    jif.tck = 1'b0;
    jif.tms = 1'b1;
    jif.tdi = 1'b0;
    cap_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(tap_state), 32'(TLR));
    chk("rst_ir", 32'(ir_value), 32'(INSTR_IDCODE_DEF));
    chk("rst_tdo", 32'(jif.tdo), 32'd0);
    chk("rst_tdo_en", 32'(jif.tdo_en), 32'd0);
    chk("rst_dr_data", 32'(dr_data), 32'd0);
    chk("rst_dr_valid", 32'(dr_valid), 32'd0);
    rst = 1'b0;
    mon_on = 1'b1;
    model_ir = INSTR_IDCODE_DEF;
    tick(1'b0, 1'b0);
    shift_ir(INSTR_DATA_DEF);
    mon_on = 1'b0;
    cap_data = 8'hFF;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'($urandom));
    chk("pre_rst_tdo_en", 32'(jif.tdo_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", 32'(tap_state), 32'(TLR));
    chk("mid_rst_tdo", 32'(jif.tdo), 32'd0);
    chk("mid_rst_tdo_en", 32'(jif.tdo_en), 32'd0);
    chk("mid_rst_ir", 32'(ir_value), 32'(INSTR_IDCODE_DEF));
    rst = 1'b0;
    mon_on = 1'b1;
    model_ir = INSTR_IDCODE_DEF;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("mid_rst_dr_data", 32'(dr_data), 32'd0);
    chk("mid_rst_dr_valid", 32'(dr_valid), 32'd0);
    tick(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      mon_on = 1'b0;
      repeat ($urandom_range(3, 20)) tick(1'($urandom), 1'($urandom));
      goto_tlr();
      mon_on = 1'b1;
    end
    shift_ir(INSTR_DATA_DEF);
    shift_dr(8, 64'h5A, 8'hC3, -1);
    for (int k = 0; k < 6; k++) shift_dr(8, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 9));
    goto_tlr();
    shift_dr(32, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 40));
    shift_ir(10'h3FF);
    shift_dr(4, 64'b1101, 8'h00, -1);
    code = 10'($urandom);
    if (code == INSTR_DATA_DEF || code == INSTR_IDCODE_DEF) code = code ^ 10'h200;
    shift_ir(code);
    shift_dr($urandom_range(1, 12), {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 12));
    repeat (10) @(negedge clk);
    chk("tdo_queue_empty", 32'(exp_tdo_q.size()), 32'd0);
    chk("dr_queue_empty", 32'(exp_dr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
